// File: rtl/operand_loader_fsm_if.sv
// ---------------------------------------------------------------------------
// operand_loader_fsm_if
// Bundles the operand bus, load/clear controls, downstream handshake and
// status outputs of operand_loader_fsm.
//   master : environment side (drives switches/button/clear/op_ready)
//   slave  : loader side (drives registered operands and status)
// Signals:
//   data_in   [N]     shared operand switch bus
//   load_btn          load request level, rising edge = load event
//   clear             synchronous abort/clear
//   op_ready          downstream accepts the operand pair
//   a_out/b_out [N]   registered operands
//   op_valid          operand pair complete and stable
//   state_o   [2]     current FSM state
//   txn_count [CNT_W] accepted operand pairs, wrapping
// ---------------------------------------------------------------------------
interface operand_loader_fsm_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic [N-1:0]     data_in;
  logic             load_btn;
  logic             clear;
  logic             op_ready;
  logic [N-1:0]     a_out;
  logic [N-1:0]     b_out;
  logic             op_valid;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] txn_count;

  modport master (
    output data_in, load_btn, clear, op_ready,
    input  a_out, b_out, op_valid, state_o, txn_count
  );

  modport slave (
    input  data_in, load_btn, clear, op_ready,
    output a_out, b_out, op_valid, state_o, txn_count
  );
endinterface

// File: rtl/operand_loader_fsm.sv
// ---------------------------------------------------------------------------
// operand_loader_fsm
// Captures operand A then operand B from a shared switch bus on successive
// rising edges of a load button, then presents the pair with a valid/ready
// handshake and counts accepted pairs.
// Ports:
//   clk  system clock (rising edge)
//   rst  asynchronous active-high reset
//   bus  operand_loader_fsm_if.slave (data_in, load_btn, clear, op_ready in;
//        a_out, b_out, op_valid, state_o, txn_count out)
// Optional build macro:
//   OPERAND_SYNC_EN  adds a 2-flop synchronizer (reset to 1) on load_btn
//                    ahead of the edge detector, +2 cycles load latency.
// ---------------------------------------------------------------------------
module operand_loader_fsm #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                rst,
  operand_loader_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    VALID  = 2'b10,
    UNUSED = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_in;
  logic             btn_q;
  logic             load_evt;

`ifdef OPERAND_SYNC_EN
  // Stage p0/p1: button synchronizer; reset high so a held button is not
  // seen as a fresh press after reset.
  logic btn_p0, btn_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_p0 <= 1'b1;
      btn_p1 <= 1'b1;
    end else begin
      btn_p0 <= bus.load_btn;
      btn_p1 <= btn_p0;
    end
  end

  assign btn_in = btn_p1;
`else
  assign btn_in = bus.load_btn;
`endif

  // Edge detector: btn_q resets high so a button held through reset
  // release produces no event; it keeps tracking even while clear is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= 1'b1;
    end else begin
      btn_q <= btn_in;
    end
  end

  assign load_evt = btn_in & ~btn_q;

  // Next-state and datapath update; clear outranks both load and handshake.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    if (bus.clear) begin
      state_d = WAIT_A;
      a_d     = '0;
      b_d     = '0;
    end else begin
      case (state_q)
        WAIT_A: begin
          if (load_evt) begin
            a_d     = bus.data_in;
            state_d = WAIT_B;
          end
        end
        WAIT_B: begin
          if (load_evt) begin
            b_d     = bus.data_in;
            state_d = VALID;
          end
        end
        VALID: begin
          // Load events here are dropped, even alongside op_ready.
          if (bus.op_ready) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = WAIT_A;
          end
        end
        default: state_d = WAIT_A;
      endcase
    end
    // op_valid is registered so it rises on the same edge VALID is entered.
    vld_d = (state_d == VALID);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.op_valid  = vld_q;
  assign bus.state_o   = state_q;
  assign bus.txn_count = cnt_q;

endmodule
